// File: rtl/id_stage_pipe_if.sv
// Bundle of every IF/ID, bypass and ID/EX signal around the decode stage.
// The master modport is the decode stage itself; the slave modport is the
// surrounding pipeline (fetch, regfile, bypass network and execute).
interface id_stage_pipe_if #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int RA_W    = 5
);
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_instr;
    logic [XLEN-1:0]         in_pc;
    logic                    flush;
    logic [XLEN-1:0]         rf_rdata1;
    logic [XLEN-1:0]         rf_rdata2;
    logic [NUM_FWD-1:0]      fwd_valid;
    logic [NUM_FWD-1:0]      fwd_pending;
    logic [NUM_FWD*RA_W-1:0] fwd_rd;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_branch;
    logic                    out_jal;
    logic                    out_jalr;
    logic                    out_memread;
    logic                    out_memtoreg;
    logic                    out_memwrite;
    logic                    out_alusrc;
    logic                    out_regwrite;
    logic                    out_illegal;
    logic [3:0]              out_aluop;
    logic [2:0]              out_func3;
    logic [XLEN-1:0]         out_imm;
    logic [RA_W-1:0]         out_rs1;
    logic [RA_W-1:0]         out_rs2;
    logic [RA_W-1:0]         out_rd;
    logic [XLEN-1:0]         out_rs1_data;
    logic [XLEN-1:0]         out_rs2_data;
    logic [XLEN-1:0]         out_pc;

    modport master (
        input  in_valid, in_instr, in_pc, flush, rf_rdata1, rf_rdata2,
               fwd_valid, fwd_pending, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, out_branch, out_jal, out_jalr, out_memread,
               out_memtoreg, out_memwrite, out_alusrc, out_regwrite, out_illegal,
               out_aluop, out_func3, out_imm, out_rs1, out_rs2, out_rd,
               out_rs1_data, out_rs2_data, out_pc
    );

    modport slave (
        output in_valid, in_instr, in_pc, flush, rf_rdata1, rf_rdata2,
               fwd_valid, fwd_pending, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, out_branch, out_jal, out_jalr, out_memread,
               out_memtoreg, out_memwrite, out_alusrc, out_regwrite, out_illegal,
               out_aluop, out_func3, out_imm, out_rs1, out_rs2, out_rd,
               out_rs1_data, out_rs2_data, out_pc
    );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I decode stage owning the ID/EX register: decodes controls and
// immediates, resolves operands through the bypass sources, stalls on
// load-use and talks valid/ready on both sides.
module id_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int RA_W    = 5
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.master bus
);
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            memread;
        logic            memtoreg;
        logic            memwrite;
        logic            alusrc;
        logic            regwrite;
        logic            illegal;
        logic [3:0]      aluop;
        logic [2:0]      func3;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] pc;
    } payload_t;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [RA_W-1:0] rs1_idx;
    logic [RA_W-1:0] rs2_idx;
    logic [31:0]     i_imm, s_imm, b_imm, j_imm, u_imm;

    assign instr   = bus.in_instr;
    assign opcode  = instr[6:0];
    assign func3   = instr[14:12];
    assign rs1_idx = RA_W'(instr[19:15]);
    assign rs2_idx = RA_W'(instr[24:20]);
    assign i_imm   = {{20{instr[31]}}, instr[31:20]};
    assign s_imm   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign j_imm   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign u_imm   = {instr[31:12], 12'b0};

    // Unpack the flattened bypass buses and find per-source address hits.
    logic [RA_W-1:0]    fwd_rd_a   [NUM_FWD];
    logic [XLEN-1:0]    fwd_data_a [NUM_FWD];
    logic [NUM_FWD-1:0] hit1, hit2;

    for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
        assign fwd_rd_a[gi]   = bus.fwd_rd[gi*RA_W +: RA_W];
        assign fwd_data_a[gi] = bus.fwd_data[gi*XLEN +: XLEN];
        assign hit1[gi]       = bus.fwd_valid[gi] && (fwd_rd_a[gi] == rs1_idx);
        assign hit2[gi]       = bus.fwd_valid[gi] && (fwd_rd_a[gi] == rs2_idx);
    end

    // Youngest matching source wins; its pending flag is the one that counts,
    // so an older ready copy never masks an in-flight load.
    logic [XLEN-1:0] op1, op2;
    logic            pend1, pend2, found1, found2;

    always_comb begin
        op1    = bus.rf_rdata1;
        op2    = bus.rf_rdata2;
        pend1  = 1'b0;
        pend2  = 1'b0;
        found1 = 1'b0;
        found2 = 1'b0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (!found1 && hit1[i]) begin
                found1 = 1'b1;
                op1    = fwd_data_a[i];
                pend1  = bus.fwd_pending[i];
            end
            if (!found2 && hit2[i]) begin
                found2 = 1'b1;
                op2    = fwd_data_a[i];
                pend2  = bus.fwd_pending[i];
            end
        end
        if (rs1_idx == '0) begin
            op1   = '0;
            pend1 = 1'b0;
        end
        if (rs2_idx == '0) begin
            op2   = '0;
            pend2 = 1'b0;
        end
    end

    // Opcode decode into the payload that will be captured on accept.
    payload_t    dec;
    logic [31:0] imm32;
    logic        use_rs1, use_rs2;

    always_comb begin
        dec     = '0;
        imm32   = '0;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        case (opcode)
            OP_IMM: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.aluop    = {(func3 == 3'b101) && instr[30], func3};
                imm32        = i_imm;
            end
            OP_REG: begin
                dec.regwrite = 1'b1;
                dec.aluop    = {instr[30], func3};
                use_rs2      = 1'b1;
            end
            OP_LOAD: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                imm32        = i_imm;
            end
            OP_STORE: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                imm32        = s_imm;
                use_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                imm32        = b_imm;
                use_rs2      = 1'b1;
            end
            OP_JAL: begin
                dec.regwrite = 1'b1;
                dec.jal      = 1'b1;
                dec.branch   = 1'b1;
                imm32        = j_imm;
                use_rs1      = 1'b0;
            end
            OP_JALR: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.jalr     = 1'b1;
                dec.branch   = 1'b1;
                imm32        = i_imm;
            end
            OP_LUI, OP_AUIPC: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                imm32        = u_imm;
                use_rs1      = 1'b0;
            end
            default: begin
                dec.illegal  = 1'b1;
            end
        endcase
        dec.func3    = func3;
        dec.imm      = XLEN'($signed(imm32));
        dec.rs1      = rs1_idx;
        dec.rs2      = rs2_idx;
        dec.rd       = RA_W'(instr[11:7]);
        dec.rs1_data = op1;
        dec.rs2_data = op2;
        dec.pc       = bus.in_pc;
    end

    payload_t payload_d, payload_q;
    logic     out_valid_d, out_valid_q;
    logic     hazard;
    logic     accept;

    assign hazard       = (use_rs1 && pend1) || (use_rs2 && pend2);
    assign bus.in_ready = !rst && !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Next ID/EX contents: flush beats accept, accept beats drain, else hold.
    always_comb begin
        payload_d   = payload_q;
        out_valid_d = out_valid_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            payload_d   = dec;
            out_valid_d = 1'b1;
        end else if (bus.out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    // ID/EX pipeline register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            payload_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            payload_q   <= payload_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_branch   = payload_q.branch;
    assign bus.out_jal      = payload_q.jal;
    assign bus.out_jalr     = payload_q.jalr;
    assign bus.out_memread  = payload_q.memread;
    assign bus.out_memtoreg = payload_q.memtoreg;
    assign bus.out_memwrite = payload_q.memwrite;
    assign bus.out_alusrc   = payload_q.alusrc;
    assign bus.out_regwrite = payload_q.regwrite;
    assign bus.out_illegal  = payload_q.illegal;
    assign bus.out_aluop    = payload_q.aluop;
    assign bus.out_func3    = payload_q.func3;
    assign bus.out_imm      = payload_q.imm;
    assign bus.out_rs1      = payload_q.rs1;
    assign bus.out_rs2      = payload_q.rs2;
    assign bus.out_rd       = payload_q.rd;
    assign bus.out_rs1_data = payload_q.rs1_data;
    assign bus.out_rs2_data = payload_q.rs2_data;
    assign bus.out_pc       = payload_q.pc;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for the decode stage: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the ID/EX register.
module tb_id_stage_pipe;
    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int RA_W    = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RA_W(RA_W)) bus ();
    id_stage_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .RA_W(RA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        branch, jal, jalr, memread, memtoreg, memwrite, alusrc, regwrite, illegal;
        logic [3:0]  aluop;
        logic [2:0]  func3;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1_data, rs2_data, pc;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q = '0;
    logic exp_valid = 1'b0;
    logic last_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Operand as the bypass rules define it: x0 is zero, otherwise the
    // lowest-index valid source naming the register, otherwise the regfile.
    function automatic void ref_operand(input logic [4:0] rs, input logic [31:0] rf,
                                        output logic [31:0] d, output logic pend);
        d    = rf;
        pend = 1'b0;
        if (rs == 5'd0) begin
            d = 32'd0;
            return;
        end
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (bus.fwd_valid[i] && bus.fwd_rd[i*RA_W +: RA_W] == rs) begin
                d    = bus.fwd_data[i*XLEN +: XLEN];
                pend = bus.fwd_pending[i];
            end
        end
    endfunction

    // Instruction-class predicates for the word currently on in_instr.
    function automatic logic [8:0] classes();
        logic [6:0] op;
        op = bus.in_instr[6:0];
        // {auipc, lui, jalr, jal, br, st, ld, r, i}
        return {op == 7'h17, op == 7'h37, op == 7'h67, op == 7'h6F, op == 7'h63,
                op == 7'h23, op == 7'h03, op == 7'h33, op == 7'h13};
    endfunction

    function automatic logic ref_hazard();
        logic [8:0]  c;
        logic [31:0] d;
        logic        p1, p2, uses1, uses2;
        c     = classes();
        uses1 = !(c[5] || c[7] || c[8]);
        uses2 = c[1] || c[3] || c[4];
        ref_operand(bus.in_instr[19:15], bus.rf_rdata1, d, p1);
        ref_operand(bus.in_instr[24:20], bus.rf_rdata2, d, p2);
        return (uses1 && p1) || (uses2 && p2);
    endfunction

    function automatic exp_t ref_decode();
        exp_t        e;
        logic [31:0] ins;
        logic [8:0]  c;
        logic        is_i, is_r, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
        logic        p;
        int          s;
        e   = '0;
        ins = bus.in_instr;
        s   = ins;
        c   = classes();
        {is_auipc, is_lui, is_jalr, is_jal, is_br, is_st, is_ld, is_r, is_i} = c;
        e.illegal  = (c == 9'd0);
        e.regwrite = is_r || is_i || is_ld || is_jal || is_jalr || is_lui || is_auipc;
        e.alusrc   = is_i || is_ld || is_st || is_jalr || is_lui || is_auipc;
        e.memread  = is_ld;
        e.memtoreg = is_ld;
        e.memwrite = is_st;
        e.branch   = is_br || is_jal || is_jalr;
        e.jal      = is_jal;
        e.jalr     = is_jalr;
        if (is_r || is_i) e.aluop[2:0] = ins[14:12];
        if (is_r || (is_i && ins[14:12] == 3'b101)) e.aluop[3] = ins[30];
        e.func3 = ins[14:12];
        if (is_i || is_ld || is_jalr)
            e.imm = 32'(s >>> 20);
        else if (is_st)
            e.imm = 32'((s >>> 25) * 32) | 32'(ins[11:7]);
        else if (is_br)
            e.imm = 32'((s >>> 31) * 4096) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        else if (is_jal)
            e.imm = 32'((s >>> 31) * (1 << 20)) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        else if (is_lui || is_auipc)
            e.imm = ins & 32'hFFFFF000;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.pc  = bus.in_pc;
        ref_operand(e.rs1, bus.rf_rdata1, e.rs1_data, p);
        ref_operand(e.rs2, bus.rf_rdata2, e.rs2_data, p);
        return e;
    endfunction

    // One clock: check in_ready, advance the model, then check every output.
    task automatic cycle(input string tag);
        logic exp_ready;
        exp_t nx;
        #3;
        exp_ready  = !rst && !bus.flush && !ref_hazard() && (!exp_valid || bus.out_ready);
        last_ready = bus.in_ready;
        check({tag, ".in_ready"}, bus.in_ready, exp_ready);
        nx = ref_decode();
        if (rst) begin
            exp_valid = 1'b0;
            exp_q     = '0;
        end else if (bus.flush) begin
            exp_valid = 1'b0;
        end else if (bus.in_valid && exp_ready) begin
            exp_valid = 1'b1;
            exp_q     = nx;
        end else if (bus.out_ready && exp_valid) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, ".valid"}, bus.out_valid, exp_valid);
        check({tag, ".ctrl"}, {bus.out_branch, bus.out_jal, bus.out_jalr, bus.out_memread,
                               bus.out_memtoreg, bus.out_memwrite, bus.out_alusrc,
                               bus.out_regwrite, bus.out_illegal, bus.out_aluop, bus.out_func3},
              {exp_q.branch, exp_q.jal, exp_q.jalr, exp_q.memread, exp_q.memtoreg,
               exp_q.memwrite, exp_q.alusrc, exp_q.regwrite, exp_q.illegal, exp_q.aluop, exp_q.func3});
        check({tag, ".imm"}, bus.out_imm, exp_q.imm);
        check({tag, ".regs"}, {bus.out_rs1, bus.out_rs2, bus.out_rd}, {exp_q.rs1, exp_q.rs2, exp_q.rd});
        check({tag, ".rs1_data"}, bus.out_rs1_data, exp_q.rs1_data);
        check({tag, ".rs2_data"}, bus.out_rs2_data, exp_q.rs2_data);
        check({tag, ".pc"}, bus.out_pc, exp_q.pc);
        $display("[TB] %s instr=%h acc_rdy=%0b out_valid=%0b pc=%h", tag, bus.in_instr,
                 last_ready, bus.out_valid, bus.out_pc);
    endtask

    logic [6:0]  ops [10] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    logic [31:0] rnd;

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_instr    = 32'h0;
        bus.in_pc       = 32'h0;
        bus.flush       = 1'b0;
        bus.rf_rdata1   = 32'h1111;
        bus.rf_rdata2   = 32'h2222;
        bus.fwd_valid   = '0;
        bus.fwd_pending = '0;
        bus.fwd_rd      = '0;
        bus.fwd_data    = '0;
        bus.out_ready   = 1'b1;
        @(posedge clk);
        #1;
        cycle("reset0");
        cycle("reset1");
        check("reset.out_imm", bus.out_imm, 32'h0);
        rst = 1'b0;

        // addi x1,x0,-5
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hFFB00093;
        bus.in_pc    = 32'h100;
        cycle("t1_addi");
        check("t1.imm", bus.out_imm, 32'hFFFFFFFB);
        check("t1.rd_regwrite_alusrc", {bus.out_rd, bus.out_regwrite, bus.out_alusrc}, {5'd1, 1'b1, 1'b1});

        // add x3,x1,x2 with both sources naming x1
        bus.in_instr  = 32'h002081B3;
        bus.in_pc     = 32'h104;
        bus.fwd_valid = 2'b11;
        bus.fwd_rd    = {5'd1, 5'd1};
        bus.fwd_data  = {32'hBB, 32'hAA};
        cycle("t2_fwd");
        check("t2.rs1_data", bus.out_rs1_data, 32'hAA);
        check("t2.rs2_data", bus.out_rs2_data, 32'h2222);

        // load-use on x5 from the youngest source
        bus.in_instr    = 32'h00128313;
        bus.in_pc       = 32'h108;
        bus.fwd_valid   = 2'b01;
        bus.fwd_rd      = {5'd0, 5'd5};
        bus.fwd_pending = 2'b01;
        bus.fwd_data    = {32'h0, 32'h55};
        cycle("t3_hazard");
        check("t3.ready_low", last_ready, 1'b0);
        check("t3.bubble", bus.out_valid, 1'b0);
        bus.fwd_pending = 2'b00;
        cycle("t3_release");
        check("t3.rs1_data", bus.out_rs1_data, 32'h55);

        // EX back-pressure for three cycles
        bus.fwd_valid = 2'b00;
        bus.out_ready = 1'b0;
        bus.in_instr  = 32'h00308393;
        bus.in_pc     = 32'h10C;
        for (int i = 0; i < 3; i++) begin
            cycle("t4_stall");
            check("t4.ready_low", last_ready, 1'b0);
            check("t4.pc_held", bus.out_pc, 32'h108);
        end
        bus.out_ready = 1'b1;
        cycle("t4_release");
        check("t4.new_pc", bus.out_pc, 32'h10C);

        // flush with a held and an incoming instruction
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        bus.in_pc     = 32'h110;
        cycle("t5_flush");
        check("t5.flushed", bus.out_valid, 1'b0);
        bus.flush = 1'b0;
        cycle("t5_load");
        cycle("t5_stall");
        rst = 1'b1;
        cycle("t5_rst");
        check("t5.rst_pc", bus.out_pc, 32'h0);
        rst           = 1'b0;
        bus.out_ready = 1'b1;

        // illegal opcode and LUI
        bus.in_instr = 32'h0000007F;
        cycle("t6_illegal");
        check("t6.illegal", {bus.out_illegal, bus.out_regwrite, bus.out_alusrc}, 3'b100);
        bus.in_instr = 32'h123450B7;
        cycle("t6_lui");
        check("t6.lui_imm", bus.out_imm, 32'h12345000);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            rnd                   = $urandom;
            bus.in_instr          = {rnd[31:7], ops[$urandom_range(0, 9)]};
            bus.in_instr[19:15]   = 5'($urandom_range(0, 3));
            bus.in_instr[24:20]   = 5'($urandom_range(0, 3));
            bus.in_pc             = $urandom;
            bus.in_valid          = ($urandom % 4) != 0;
            bus.out_ready         = ($urandom % 4) != 0;
            bus.flush             = ($urandom % 12) == 0;
            rst                   = ($urandom % 60) == 0;
            bus.rf_rdata1         = $urandom;
            bus.rf_rdata2         = $urandom;
            bus.fwd_valid         = 2'($urandom);
            bus.fwd_pending       = {($urandom % 4) == 0, ($urandom % 4) == 0};
            bus.fwd_rd            = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            bus.fwd_data          = {$urandom, $urandom};
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
